// File: rtl/serial_sub_sequencer_if.sv
// Handshake and datapath bundle between the serial subtractor sequencer and its surroundings.
// master = the sequencer, slave = the upstream/downstream/subtractor side.
interface serial_sub_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_A;
  logic [7:0] in_B;
  logic [7:0] sub_A;
  logic [7:0] sub_B;
  logic       sub_Reset;
  logic [7:0] sub_Diff;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_Diff;
  logic       out_Borrow;
  logic       out_Ovf;
  logic       busy;

  modport master (
    input  in_valid, in_A, in_B, sub_Diff, out_ready,
    output in_ready, sub_A, sub_B, sub_Reset, out_valid, out_Diff, out_Borrow, out_Ovf, busy
  );

  modport slave (
    output in_valid, in_A, in_B, sub_Diff, out_ready,
    input  in_ready, sub_A, sub_B, sub_Reset, out_valid, out_Diff, out_Borrow, out_Ovf, busy
  );
endinterface

// File: rtl/serial_sub_sequencer.sv
// Operand FIFO and sequencer for the 8-bit serial subtractor; result valid SHIFT_CYCLES+3 cycles after accept.
// in_ready reflects FIFO space only; a captured result waits in HOLD until out_ready, however long that takes.
module serial_sub_sequencer #(
  parameter int DEPTH        = 2,
  parameter int SHIFT_CYCLES = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  serial_sub_sequencer_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(SHIFT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [7:0]      fifo_a [DEPTH];
  logic [7:0]      fifo_b [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, capture;
  logic [NW-1:0]   cnt;
  logic [7:0]      op_a, op_b, diff_q;
  logic            borrow_q, ovf_q, valid_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign bus.in_ready = (count < CW'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_A;
      fifo_b[wr_ptr] <= bus.in_B;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == NW'(1)) state_nxt = CAPTURE;
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_a     <= '0;
      op_b     <= '0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      if (pop) begin
        op_a <= fifo_a[rd_ptr];
        op_b <= fifo_b[rd_ptr];
      end
      if (state == LOAD)     cnt <= NW'(SHIFT_CYCLES);
      else if (state == RUN) cnt <= cnt - NW'(1);
      // The subtractor's register is trusted to hold A-B once the shift window has elapsed.
      if (capture) begin
        diff_q   <= bus.sub_Diff;
        borrow_q <= (op_a < op_b);
        ovf_q    <= (op_a[7] != op_b[7]) && (bus.sub_Diff[7] != op_a[7]);
        valid_q  <= 1'b1;
      end else if ((state == HOLD) && bus.out_ready) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign bus.sub_A      = op_a;
  assign bus.sub_B      = op_b;
  assign bus.sub_Reset  = Reset | (state == LOAD);
  assign bus.out_valid  = valid_q;
  assign bus.out_Diff   = diff_q;
  assign bus.out_Borrow = borrow_q;
  assign bus.out_Ovf    = ovf_q;
  assign bus.busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Randomized and directed bench for serial_sub_sequencer with a bit-serial subtractor model
// and a queue-based scoreboard computing results from plain integer arithmetic.
module tb_serial_sub_sequencer;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  serial_sub_sequencer_if bus();

  serial_sub_sequencer #(.DEPTH(2), .SHIFT_CYCLES(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Bit-serial subtractor: LSB first, difference shifted in from the MSB end.
  logic [7:0] s_a = '0, s_b = '0, s_d = '0;
  logic       s_br = 1'b0;
  logic [3:0] s_k = 4'd8;
  always @(posedge Clock) begin
    if (bus.sub_Reset) begin
      s_a <= bus.sub_A; s_b <= bus.sub_B; s_d <= '0; s_br <= 1'b0; s_k <= 4'd0;
    end else if (s_k < 4'd8) begin
      s_d  <= {s_a[s_k[2:0]] ^ s_b[s_k[2:0]] ^ s_br, s_d[7:1]};
      s_br <= (~s_a[s_k[2:0]] & s_b[s_k[2:0]]) | (~(s_a[s_k[2:0]] ^ s_b[s_k[2:0]]) & s_br);
      s_k  <= s_k + 4'd1;
    end
  end
  assign bus.sub_Diff = s_d;

  typedef struct { logic [7:0] a; logic [7:0] b; int t; } job_t;
  job_t exp_q[$];
  int   rises[$];
  int   checks = 0, errors = 0;
  int   n = 0, xfers = 0, srst_cnt = 0;
  bit   lat_chk = 1'b0;
  logic pv = 1'b0, pxfer = 1'b0, pb = 1'b0, po = 1'b0;
  logic [7:0] pd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Monitor: samples at the falling edge what the next rising edge will act on.
  initial forever begin
    @(negedge Clock);
    n++;
    if (Reset) begin
      exp_q.delete();
      pv = 1'b0;
    end else begin
      if (bus.sub_Reset) begin
        srst_cnt++;
        // accept is sampled one falling edge before its rising edge
        if (lat_chk && exp_q.size() > 0) chk("load_cycle", n - exp_q[0].t - 1, 1);
      end
      if (bus.out_valid) begin
        if (!pv || pxfer) begin
          rises.push_back(n);
          if (lat_chk && exp_q.size() > 0) chk("latency", n - exp_q[0].t - 1, 11);
        end else begin
          chk("hold_diff", bus.out_Diff, pd);
          chk("hold_borrow", bus.out_Borrow, pb);
          chk("hold_ovf", bus.out_Ovf, po);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        xfers++;
        if (exp_q.size() == 0) chk("out_unexpected", bus.out_valid, 0);
        else begin
          job_t j;
          int   sdiff;
          j     = exp_q.pop_front();
          sdiff = int'($signed(j.a)) - int'($signed(j.b));
          chk("diff", bus.out_Diff, (int'(j.a) - int'(j.b) + 256) % 256);
          chk("borrow", bus.out_Borrow, int'(j.a) < int'(j.b));
          chk("ovf", bus.out_Ovf, (sdiff < -128) || (sdiff > 127));
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back('{bus.in_A, bus.in_B, n});
      pv = bus.out_valid; pxfer = bus.out_valid && bus.out_ready;
      pd = bus.out_Diff; pb = bus.out_Borrow; po = bus.out_Ovf;
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, output bit ok);
    bus.in_valid = 1'b1; bus.in_A = a; bus.in_B = b;
    @(negedge Clock); ok = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    int i = 0;
    @(negedge Clock);
    while (!bus.out_valid && i < max) begin @(negedge Clock); i++; end
    chk("wait_valid", bus.out_valid, 1);
    tick();
  endtask

  task automatic drain(input int max);
    int i = 0;
    bus.out_ready = 1'b1;
    @(negedge Clock);
    while ((exp_q.size() != 0 || bus.busy || bus.out_valid) && i < max) begin @(negedge Clock); i++; end
    chk("drain_busy", bus.busy, 0);
    chk("drain_queue", exp_q.size(), 0);
    tick();
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0, x0, r0;
    Reset = 1'b1; bus.in_valid = 1'b0; bus.in_A = '0; bus.in_B = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_sub_reset", bus.sub_Reset, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    @(posedge Clock); #1 Reset = 1'b0;
    @(negedge Clock);
    chk("post_rst_valid", bus.out_valid, 0);
    chk("post_rst_diff", bus.out_Diff, 0);
    chk("post_rst_borrow", bus.out_Borrow, 0);
    chk("post_rst_ovf", bus.out_Ovf, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_sub_a", bus.sub_A, 0);
    chk("post_rst_sub_b", bus.sub_B, 0);
    chk("post_rst_sub_reset", bus.sub_Reset, 0);
    tick();

    // Single job into an empty block, then borrow and overflow cases
    bus.out_ready = 1'b1; lat_chk = 1'b1; c0 = srst_cnt;
    push(8'd100, 8'd37, ok); chk("t1_accept", ok, 1);
    drain(40);
    chk("t1_sub_reset_pulses", srst_cnt - c0, 1);
    push(8'd5, 8'd9, ok);     drain(40);
    push(8'h80, 8'h01, ok);   drain(40);
    lat_chk = 1'b0;

    // Backpressure: 1 in flight + 2 buffered, the 4th refused
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(pick(), pick(), ok);
      chk($sformatf("bp_accept%0d", i), ok, i < 3);
    end
    repeat (20) tick();
    @(negedge Clock);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_valid", bus.out_valid, 1);
    tick();
    r0 = rises.size(); x0 = xfers;
    drain(200);
    chk("bp_xfers", xfers - x0, 3);
    chk("bp_rises", rises.size() - r0, 2);
    chk("bp_spacing", rises[rises.size()-1] - rises[rises.size()-2], 12);

    // out_ready early is ignored; long HOLD; one-cycle out_ready gives one transfer
    bus.out_ready = 1'b0;
    push(8'd200, 8'd17, ok);
    repeat (3) tick();
    bus.out_ready = 1'b1; repeat (3) tick(); bus.out_ready = 1'b0;
    wait_valid(30);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock); chk("hold_valid", bus.out_valid, 1);
      tick();
    end
    x0 = xfers;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    @(negedge Clock);
    chk("one_xfer", xfers - x0, 1);
    chk("after_xfer_valid", bus.out_valid, 0);
    tick();
    drain(40);

    // Reset during RUN (cnt=4) with one pair buffered
    bus.out_ready = 1'b1;
    push(8'd33, 8'd44, ok);
    push(8'd55, 8'd66, ok);
    repeat (5) tick();
    Reset = 1'b1;
    @(negedge Clock); chk("mid_rst_sub_reset", bus.sub_Reset, 1);
    tick(); Reset = 1'b0;
    @(negedge Clock);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    x0 = xfers;
    repeat (30) @(negedge Clock);
    chk("mid_rst_no_output", xfers - x0, 0);
    tick();
    lat_chk = 1'b1;
    push(8'd77, 8'd250, ok); drain(40);
    lat_chk = 1'b0;

    // Push and pop together in IDLE with one entry buffered
    bus.out_ready = 1'b0;
    push(8'd10, 8'd3, ok);
    push(8'd3, 8'd10, ok);
    wait_valid(30);
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_A = 8'h7F; bus.in_B = 8'hFF;
    @(negedge Clock);
    chk("pp_in_ready", bus.in_ready, 1);
    chk("pp_busy", bus.busy, 1);
    tick(); bus.in_valid = 1'b0;
    push(8'hFF, 8'h7F, ok); chk("pp_count_room", ok, 1);
    @(negedge Clock); chk("pp_full", bus.in_ready, 0);
    tick();
    drain(100);

    // Randomized traffic
    repeat (300) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_A      = pick();
      bus.in_B      = pick();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    drain(500);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub_sequencer.md
# serial_sub_sequencer

Front-end and result-collection stage for the 8-bit serial subtractor. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. For each pair it drives the subtractor's parallel operands and load/reset strobe, then waits out the bit-serial shift window. It captures the difference, derives borrow and signed-overflow flags, and presents the result downstream under a second valid/ready handshake.

## Interface
- `DEPTH`, default 2: operand FIFO entries (≥1).
- `SHIFT_CYCLES`, default 8: subtractor shift cycles after the load edge.
- `Clock` in 1: clock, all state updates on rising edge.
- `Reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO can accept.
- `in_A` in 8: minuend.
- `in_B` in 8: subtrahend.
- `sub_A` out 8: minuend to subtractor.
- `sub_B` out 8: subtrahend to subtractor.
- `sub_Reset` out 1: subtractor load/reset strobe.
- `sub_Diff` in 8: subtractor difference register.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts.
- `out_Diff` out 8: A−B mod 256.
- `out_Borrow` out 1: unsigned A<B.
- `out_Ovf` out 1: two's-complement overflow of A−B.
- `busy` out 1: FSM not in IDLE or FIFO non-empty.

## Operation
- FIFO push on `in_valid && in_ready`. `in_ready = (fifo_count < DEPTH)` only, with no combinational dependence on pop; push and pop in the same cycle are both honoured and the count is unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, RUN, CAPTURE, HOLD.
- **IDLE:** if the FIFO is non-empty, pop the head into opA/opB registers and go to LOAD; otherwise stay.
- **LOAD:** `sub_Reset=1` for exactly this one cycle, with `sub_A=opA` and `sub_B=opB`. Load cnt=SHIFT_CYCLES and go to RUN.
- **RUN:** decrement cnt each cycle; on the cycle cnt==1, go to CAPTURE. RUN lasts exactly SHIFT_CYCLES cycles.
- **CAPTURE:** on the exit edge, register `out_Diff<=sub_Diff`, `out_Borrow<=(opA<opB)`, `out_Ovf<=(opA[7]!=opB[7])&&(sub_Diff[7]!=opA[7])`, `out_valid<=1`. Go to HOLD.
- **HOLD:** `out_valid=1`, and out_Diff/out_Borrow/out_Ovf are held stable. On `out_ready`, clear `out_valid` on that edge and go to IDLE.
- `sub_A`/`sub_B` are driven from opA/opB and stay constant from LOAD through CAPTURE.
- `sub_Reset = Reset | (state==LOAD)`, so the subtractor is held reset while the sequencer is.
- The sequencer does not check sub_Diff for correctness; it trusts the window timing.

## Timing
- **Reset values:** `out_valid=0`, `out_Diff=0`, `out_Borrow=0`, `out_Ovf=0`, `in_ready=1` (post-reset), `busy=0`, `sub_A=0`, `sub_B=0`, `sub_Reset=1` during reset, FIFO empty, state IDLE.
- **Reset mid-operation (any state):** the job in flight and all FIFO contents are discarded with no partial output. `out_valid` drops on the reset edge.
- **Empty pipeline latency:** a pair accepted at edge T gives IDLE pop at T+1, the LOAD cycle ending at T+2 (subtractor load edge), RUN through T+10, CAPTURE ending at T+11. `out_valid` is high from edge T+11, i.e. 11 cycles with defaults. General latency is SHIFT_CYCLES+3.
- **Throughput:** one result per SHIFT_CYCLES+4 cycles minimum, since HOLD takes at least 1 cycle and IDLE 1 cycle.
- **`out_ready` asserted before HOLD** is ignored; only a HOLD-cycle `out_ready` completes the transfer.
- **Backpressure:** HOLD persists indefinitely. The FIFO keeps accepting until full, then `in_ready=0` until the next pop.
- **DEPTH=1:** `in_ready` returns high in the cycle after the IDLE pop.

## Test plan
- Push A=100, B=37 into an idle block with `out_ready=1` → `out_valid` at T+11 with Diff=63, Borrow=0, Ovf=0; `sub_Reset` is high for exactly 1 cycle at T+1..T+2.
- Push A=5, B=9 → Diff=252 (0xFC), Borrow=1, Ovf=0. Then push A=0x80, B=0x01 → Diff=0x7F, Borrow=0, Ovf=1.
- DEPTH=2, hold `out_ready=0`, push 4 pairs back-to-back → first 3 accepted (1 popped plus 2 buffered), `in_ready` low from the 4th. Then release `out_ready` → results emerge in push order, each valid SHIFT_CYCLES+4 cycles apart.
- Hold `out_ready=0` for 20 cycles in HOLD → `out_valid` stays 1 and Diff/Borrow/Ovf are unchanged every cycle; one-cycle `out_ready` → exactly one transfer.
- Assert Reset for 1 cycle during RUN (cnt=4) with 1 pair buffered → next cycle: `out_valid=0`, `busy=0`, FIFO empty, `sub_Reset` was 1. A fresh pair afterwards completes correctly in 11 cycles.
- Simultaneous push and pop in IDLE with 1 entry buffered → count stays 1, no entry lost or duplicated, both results correct.
